// File: rtl/multicycle_pkg.sv
// multicycle_pkg: state codes, opcodes, datapath select encodings and control bundle
// shared by the multicycle controller and its output decoder.
`default_nettype none

package multicycle_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_EXEC_R   = 4'd2;
   localparam state_t S_EXEC_I   = 4'd3;
   localparam state_t S_WB_ALU   = 4'd4;
   localparam state_t S_MEM_ADDR = 4'd5;
   localparam state_t S_MEM_RD   = 4'd6;
   localparam state_t S_WB_MEM   = 4'd7;
   localparam state_t S_MEM_WR   = 4'd8;
   localparam state_t S_BRANCH   = 4'd9;
   localparam state_t S_JAL      = 4'd10;
   localparam state_t S_TRAP     = 4'd11;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   localparam logic [1:0] SRC_A_PC    = 2'd0;
   localparam logic [1:0] SRC_A_RS1   = 2'd1;
   localparam logic [1:0] SRC_A_OLDPC = 2'd2;

   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_FOUR = 2'd1;
   localparam logic [1:0] SRC_B_IMM  = 2'd2;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   localparam logic [1:0] PC_SRC_PC4    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   typedef struct packed {
      logic       ir_we;
      logic       pc_we;
      logic       reg_we;
      logic       mem_re;
      logic       mem_we;
      logic       instr_done;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] wb_sel;
      logic [1:0] pc_src;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // Illegal opcodes map to S_TRAP; the controller decides what that means per build.
   function automatic state_t dispatch(input logic [6:0] op);
      case (op)
         OP_R:               return S_EXEC_R;
         OP_I, OP_LUI:       return S_EXEC_I;
         OP_LOAD, OP_STORE:  return S_MEM_ADDR;
         OP_BRANCH:          return S_BRANCH;
         OP_JAL:             return S_JAL;
         default:            return S_TRAP;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_out_dec.sv
// mc_out_dec: combinational control-output decode from the current controller state.
`default_nettype none

module mc_out_dec
   import multicycle_pkg::*;
(
   input  logic [3:0]        state,
   input  logic [2:0]        funct3,
   input  logic              zero,
   input  logic              mem_ready,
   output logic [CTRL_W-1:0] ctrl
);

   ctrl_t c;
   logic  taken;

   assign taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
   assign ctrl  = c;

   always_comb begin
      c = '0;
      case (state)
         S_FETCH: begin
            c.mem_re    = 1'b1;
            c.ir_we     = mem_ready;
            c.pc_we     = mem_ready;
            c.alu_src_a = SRC_A_PC;
            c.alu_src_b = SRC_B_FOUR;
            c.alu_op    = ALU_ADD;
            c.pc_src    = PC_SRC_PC4;
         end
         S_DECODE: begin
            c.alu_src_a = SRC_A_OLDPC;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_ADD;
         end
         S_EXEC_R: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_RS2;
            c.alu_op    = ALU_FUNCT;
         end
         S_EXEC_I: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_FUNCT;
         end
         S_WB_ALU: begin
            c.reg_we     = 1'b1;
            c.wb_sel     = WB_SEL_ALU;
            c.instr_done = 1'b1;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_ADD;
         end
         S_MEM_RD: c.mem_re = 1'b1;
         S_WB_MEM: begin
            c.reg_we     = 1'b1;
            c.wb_sel     = WB_SEL_MEM;
            c.instr_done = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_we     = 1'b1;
            c.instr_done = mem_ready;
         end
         S_BRANCH: begin
            // ALUOut still holds the target computed in DECODE; the ALU now compares.
            c.alu_src_a  = SRC_A_RS1;
            c.alu_src_b  = SRC_B_RS2;
            c.alu_op     = ALU_SUB;
            c.pc_src     = PC_SRC_ALUOUT;
            c.pc_we      = taken;
            c.instr_done = 1'b1;
         end
         S_JAL: begin
            c.reg_we     = 1'b1;
            c.wb_sel     = WB_SEL_PC4;
            c.pc_we      = 1'b1;
            c.pc_src     = PC_SRC_ALUOUT;
            c.instr_done = 1'b1;
         end
         default: c = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle CPU control FSM with next-state logic and memory-wait counter.
// Optional trap support (illegal opcode, memory timeout) is enabled with MULTICYCLE_TRAP_EN.
`default_nettype none

module multicycle_ctrl
   import multicycle_pkg::*;
#(
   parameter int WAIT_W = 4
)(
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] OPCODE,
   input  logic [2:0] FUNCT3,
   input  logic       ZERO,
   input  logic       MEM_READY,
   output logic       PC_WE,
   output logic       IR_WE,
   output logic       REG_WE,
   output logic       MEM_RE,
   output logic       MEM_WE,
   output logic [1:0] ALU_SRC_A,
   output logic [1:0] ALU_SRC_B,
   output logic [1:0] ALU_OP,
   output logic [1:0] WB_SEL,
   output logic [1:0] PC_SRC,
   output logic [3:0] STATE,
   output logic       INSTR_DONE,
   output logic       TRAP,
   output logic [1:0] TRAP_CAUSE
);

   state_t state;
   state_t state_nxt;
   state_t target;
   ctrl_t  dec;
   ctrl_t  ctrl;
   logic   illegal_nop;

   assign target = dispatch(OPCODE);

   mc_out_dec u_out_dec (
      .state     (state),
      .funct3    (FUNCT3),
      .zero      (ZERO),
      .mem_ready (MEM_READY),
      .ctrl      (dec)
   );

`ifdef MULTICYCLE_TRAP_EN
   localparam state_t           ILLEGAL_NEXT = S_TRAP;
   localparam logic [WAIT_W-1:0] WAIT_LAST   = {{(WAIT_W-1){1'b1}}, 1'b0};

   logic [WAIT_W-1:0] wait_cnt;
   logic              waiting;
   logic              wait_timeout;
   logic [1:0]        cause;

   assign waiting      = !MEM_READY && ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR));
   assign wait_timeout = waiting && (wait_cnt == WAIT_LAST);
   assign illegal_nop  = 1'b0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         wait_cnt <= '0;
      else if (waiting)
         wait_cnt <= wait_cnt + 1'b1;
      else
         wait_cnt <= '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         cause <= CAUSE_NONE;
      else if ((state != S_TRAP) && (state_nxt == S_TRAP))
         cause <= wait_timeout ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
   end

   assign TRAP       = (state == S_TRAP) && !RST;
   assign TRAP_CAUSE = cause;
`else
   localparam state_t ILLEGAL_NEXT = S_FETCH;

   // Illegal opcodes retire as a NOP straight out of DECODE.
   assign illegal_nop = (state == S_DECODE) && (target == S_TRAP);
   assign TRAP        = 1'b0;
   assign TRAP_CAUSE  = 2'b00;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:            if (MEM_READY) state_nxt = S_DECODE;
         S_DECODE:           state_nxt = (target == S_TRAP) ? ILLEGAL_NEXT : target;
         S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
         S_MEM_ADDR:         state_nxt = (OPCODE == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:           if (MEM_READY) state_nxt = S_WB_MEM;
         S_MEM_WR:           if (MEM_READY) state_nxt = S_FETCH;
         S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL:
                             state_nxt = S_FETCH;
         S_TRAP:             state_nxt = S_TRAP;
         default:            state_nxt = S_FETCH;
      endcase
`ifdef MULTICYCLE_TRAP_EN
      if (wait_timeout) state_nxt = S_TRAP;
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= S_FETCH;
      else
         state <= state_nxt;
   end

   // Reset gates every output combinationally so strobes drop without waiting for CLK.
   always_comb begin
      ctrl            = dec;
      ctrl.instr_done = dec.instr_done | illegal_nop;
      if (RST) ctrl = '0;
   end

   assign PC_WE      = ctrl.pc_we;
   assign IR_WE      = ctrl.ir_we;
   assign REG_WE     = ctrl.reg_we;
   assign MEM_RE     = ctrl.mem_re;
   assign MEM_WE     = ctrl.mem_we;
   assign ALU_SRC_A  = ctrl.alu_src_a;
   assign ALU_SRC_B  = ctrl.alu_src_b;
   assign ALU_OP     = ctrl.alu_op;
   assign WB_SEL     = ctrl.wb_sel;
   assign PC_SRC     = ctrl.pc_src;
   assign INSTR_DONE = ctrl.instr_done;
   assign STATE      = state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized checks of multicycle_ctrl against a per-instruction trace model.
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_ctrl;
   import multicycle_pkg::*;

   localparam int WAIT_W = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [6:0] OPCODE = 7'd0;
   logic [2:0] FUNCT3 = 3'd0;
   logic       ZERO = 1'b0;
   logic       MEM_READY = 1'b0;
   logic       PC_WE, IR_WE, REG_WE, MEM_RE, MEM_WE;
   logic [1:0] ALU_SRC_A, ALU_SRC_B, ALU_OP, WB_SEL, PC_SRC;
   logic [3:0] STATE;
   logic       INSTR_DONE, TRAP;
   logic [1:0] TRAP_CAUSE;

   int checks = 0;
   int errors = 0;
   bit tie_ready = 1'b1;

   multicycle_ctrl #(.WAIT_W(WAIT_W)) dut (
      .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .ZERO(ZERO), .MEM_READY(MEM_READY),
      .PC_WE(PC_WE), .IR_WE(IR_WE), .REG_WE(REG_WE), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
      .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP), .WB_SEL(WB_SEL), .PC_SRC(PC_SRC),
      .STATE(STATE), .INSTR_DONE(INSTR_DONE), .TRAP(TRAP), .TRAP_CAUSE(TRAP_CAUSE)
   );

   always #5 CLK = ~CLK;

   typedef enum int {K_R, K_I, K_LUI, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_ILLEGAL} kind_t;

   typedef struct packed {
      logic [3:0] st;
      logic       ir_we, pc_we, reg_we, mem_re, mem_we, done;
      logic [1:0] wb_sel, pc_src;
      logic       rdy;
   } cyc_t;

   cyc_t q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic rnd_rdy();
      return tie_ready ? 1'b1 : 1'($urandom_range(0, 1));
   endfunction

   function automatic void push(input logic [3:0] st, input logic ir, input logic pc, input logic rg,
                                input logic re, input logic we, input logic dn,
                                input logic [1:0] wb, input logic [1:0] ps, input logic rdy);
      q.push_back({st, ir, pc, rg, re, we, dn, wb, ps, rdy});
   endfunction

   function automatic logic [6:0] op_of(input kind_t k);
      case (k)
         K_R:      return OP_R;
         K_I:      return OP_I;
         K_LUI:    return OP_LUI;
         K_LOAD:   return OP_LOAD;
         K_STORE:  return OP_STORE;
         K_BRANCH: return OP_BRANCH;
         K_JAL:    return OP_JAL;
         default:  return ($urandom_range(0, 1) != 0) ? 7'h7F : 7'h00;
      endcase
   endfunction

   // Expected cycle-by-cycle behaviour of one instruction, expanded from its class and wait counts.
   function automatic void build(input kind_t k, input int wf, input int wm);
      logic taken;
      for (int i = 0; i < wf; i++) push(S_FETCH, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 1'b0);
      push(S_FETCH, 1, 1, 0, 1, 0, 0, 2'd0, PC_SRC_PC4, 1'b1);
      push(S_DECODE, 0, 0, 0, 0, 0, (k == K_ILLEGAL), 2'd0, 2'd0, rnd_rdy());
      case (k)
         K_R: begin
            push(S_EXEC_R, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, rnd_rdy());
            push(S_WB_ALU, 0, 0, 1, 0, 0, 1, WB_SEL_ALU, 2'd0, rnd_rdy());
         end
         K_I, K_LUI: begin
            push(S_EXEC_I, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, rnd_rdy());
            push(S_WB_ALU, 0, 0, 1, 0, 0, 1, WB_SEL_ALU, 2'd0, rnd_rdy());
         end
         K_LOAD: begin
            push(S_MEM_ADDR, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, rnd_rdy());
            for (int i = 0; i < wm; i++) push(S_MEM_RD, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 1'b0);
            push(S_MEM_RD, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 1'b1);
            push(S_WB_MEM, 0, 0, 1, 0, 0, 1, WB_SEL_MEM, 2'd0, rnd_rdy());
         end
         K_STORE: begin
            push(S_MEM_ADDR, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, rnd_rdy());
            for (int i = 0; i < wm; i++) push(S_MEM_WR, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 1'b0);
            push(S_MEM_WR, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 1'b1);
         end
         K_BRANCH: begin
            case (FUNCT3)
               3'b000:  taken = ZERO;
               3'b001:  taken = !ZERO;
               default: taken = 1'b0;
            endcase
            push(S_BRANCH, 0, taken, 0, 0, 0, 1, 2'd0, PC_SRC_ALUOUT, rnd_rdy());
         end
         K_JAL:   push(S_JAL, 0, 1, 1, 0, 0, 1, WB_SEL_PC4, PC_SRC_ALUOUT, rnd_rdy());
         default: ;
      endcase
   endfunction

   // Plays up to n queued cycles (n < 0: all); starts and ends on a falling edge.
   task automatic run_q(input string tag, input int n, output int cyc);
      cyc_t c;
      cyc = 0;
      while (q.size() > 0 && n != 0) begin
         c = q.pop_front();
         MEM_READY = c.rdy;
         #1;
         chk({tag, "/trace"}, 32'({STATE, IR_WE, PC_WE, REG_WE, MEM_RE, MEM_WE, INSTR_DONE, TRAP}),
             32'({c.st, c.ir_we, c.pc_we, c.reg_we, c.mem_re, c.mem_we, c.done, 1'b0}));
         chk({tag, "/excl"}, 32'(REG_WE & MEM_WE), 32'd0);
         if (c.reg_we) chk({tag, "/wb_sel"}, 32'(WB_SEL), 32'(c.wb_sel));
         if (c.pc_we)  chk({tag, "/pc_src"}, 32'(PC_SRC), 32'(c.pc_src));
         cyc++;
         n--;
         @(negedge CLK);
      end
   endtask

   task automatic run_instr(input kind_t k, input logic [6:0] op, input logic [2:0] f3, input logic z,
                            input int wf, input int wm, input string tag, output int cyc);
      OPCODE = op;
      FUNCT3 = f3;
      ZERO   = z;
      build(k, wf, wm);
      run_q(tag, -1, cyc);
   endtask

   task automatic do_reset();
      RST       = 1'b1;
      MEM_READY = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int    cyc;
      kind_t k;

      MEM_READY = 1'b1;
      #3;
      chk("reset_state", 32'(STATE), 32'(S_FETCH));
      chk("reset_outputs", 32'({IR_WE, PC_WE, REG_WE, MEM_RE, MEM_WE, INSTR_DONE, TRAP, TRAP_CAUSE,
                                ALU_SRC_A, ALU_SRC_B, ALU_OP, WB_SEL, PC_SRC}), 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      tie_ready = 1'b1;
      run_instr(K_R, OP_R, 3'b000, 1'b0, 0, 0, "add", cyc);
      chk("add_cycles", cyc, 4);
      run_instr(K_LOAD, OP_LOAD, 3'b010, 1'b0, 0, 3, "lw_wait", cyc);
      chk("lw_cycles", cyc, 8);
      run_instr(K_BRANCH, OP_BRANCH, 3'b000, 1'b1, 0, 0, "beq", cyc);
      chk("beq_cycles", cyc, 3);
      run_instr(K_BRANCH, OP_BRANCH, 3'b001, 1'b1, 0, 0, "bne", cyc);
      chk("bne_cycles", cyc, 3);
      run_instr(K_JAL, OP_JAL, 3'b000, 1'b0, 0, 0, "jal", cyc);
      chk("jal_cycles", cyc, 3);

      // Reset pulse in the middle of a stalled store.
      OPCODE = OP_STORE;
      FUNCT3 = 3'b010;
      build(K_STORE, 0, 4);
      run_q("sw_rst", 4, cyc);
      q.delete();
      MEM_READY = 1'b0;
      #1 chk("sw_rst_memwe_before", 32'(MEM_WE), 32'd1);
      #1 RST = 1'b1;
      #1;
      chk("sw_rst_memwe_async", 32'(MEM_WE), 32'd0);
      chk("sw_rst_state", 32'(STATE), 32'(S_FETCH));
      @(negedge CLK);
      RST       = 1'b0;
      MEM_READY = 1'b1;
      #1 chk("sw_rst_first_irwe", 32'(IR_WE), 32'd1);
      @(posedge CLK);
      #1 chk("sw_rst_decode", 32'(STATE), 32'(S_DECODE));
      @(negedge CLK);
      do_reset();

      tie_ready = 1'b0;
      for (int n = 0; n < 60; n++) begin
`ifdef MULTICYCLE_TRAP_EN
         k = kind_t'($urandom_range(0, 6));
`else
         k = kind_t'($urandom_range(0, 7));
`endif
         run_instr(k, op_of(k), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), "rand", cyc);
      end
      tie_ready = 1'b1;

`ifdef MULTICYCLE_TRAP_EN
      do_reset();
      OPCODE    = 7'h7F;
      MEM_READY = 1'b1;
      #1 chk("ill_fetch", 32'(IR_WE), 32'd1);
      @(negedge CLK);
      #1 chk("ill_decode", 32'({STATE, TRAP}), 32'({S_DECODE, 1'b0}));
      @(negedge CLK);
      for (int i = 0; i < 20; i++) begin
         MEM_READY = 1'($urandom_range(0, 1));
         #1;
         chk("ill_trap", 32'({TRAP, TRAP_CAUSE, STATE}), 32'({1'b1, 2'b01, S_TRAP}));
         chk("ill_quiet", 32'({IR_WE, PC_WE, REG_WE, MEM_RE, MEM_WE, INSTR_DONE}), 32'd0);
         @(negedge CLK);
      end
      do_reset();
      chk("trap_cleared", 32'({TRAP, STATE}), 32'({1'b0, S_FETCH}));
      for (int i = 0; i < 15; i++) begin
         MEM_READY = 1'b0;
         #1 chk("to_wait", 32'({TRAP, STATE}), 32'({1'b0, S_FETCH}));
         @(negedge CLK);
      end
      #1 chk("to_trap", 32'({TRAP, TRAP_CAUSE}), 32'({1'b1, 2'b10}));
      @(negedge CLK);
      do_reset();
`else
      run_instr(K_ILLEGAL, 7'h7F, 3'b000, 1'b0, 0, 0, "nop", cyc);
      chk("nop_cycles", cyc, 2);
      #1 chk("nop_next_fetch", 32'({STATE, TRAP, TRAP_CAUSE}), 32'({S_FETCH, 1'b0, 2'b00}));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter WAIT_W, default 4: width of the memory-wait counter; timeout occurs at 2^WAIT_W-1 wait cycles.
REQ-002 SHALL have port CLK  input  1  system clock, rising-edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port OPCODE  input  7  IR[6:0] of the latched instruction.
REQ-005 SHALL have port FUNCT3  input  3  IR[14:12].
REQ-006 SHALL have port ZERO  input  1  ALU zero flag.
REQ-007 SHALL have port MEM_READY  input  1  memory completes the access this cycle.
REQ-008 SHALL have ports PC_WE, IR_WE, REG_WE, MEM_RE, MEM_WE  output  1 each  write/read strobes.
REQ-009 SHALL have ports ALU_SRC_A, ALU_SRC_B, ALU_OP, WB_SEL, PC_SRC  output  2 each  datapath mux/op selects, encodings per package.
REQ-010 SHALL have ports STATE  output  4  current state; INSTR_DONE  output  1  one-cycle retire pulse; TRAP  output  1; TRAP_CAUSE  output  2.

Function
REQ-011 SHALL implement the states FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JAL and TRAP.
REQ-012 In FETCH, SHALL assert MEM_RE; on MEM_READY=1 it SHALL also assert IR_WE and PC_WE (PC_SRC=PC+4) and go to DECODE; otherwise it SHALL hold.
REQ-013 In DECODE, SHALL compute PC+imm into ALUOut and dispatch: 0110011->EXEC_R, 0010011/0110111->EXEC_I, 0000011/0100011->MEM_ADDR, 1100011->BRANCH, 1101111->JAL, any other opcode->illegal.
REQ-014 EXEC_R and EXEC_I SHALL go to WB_ALU; WB_ALU SHALL pulse REG_WE (WB_SEL=ALU) and go to FETCH.
REQ-015 MEM_ADDR SHALL go to MEM_RD for a load and to MEM_WR for a store.
REQ-016 MEM_RD and MEM_WR SHALL hold MEM_RE or MEM_WE until MEM_READY; they SHALL then go to WB_MEM (load) or FETCH (store).
REQ-017 WB_MEM SHALL assert REG_WE with WB_SEL=MEM.
REQ-018 In BRANCH, PC_WE SHALL equal (FUNCT3==000 & ZERO) | (FUNCT3==001 & !ZERO), with PC_SRC=ALUOut; any other FUNCT3 SHALL not be taken.
REQ-019 JAL SHALL assert REG_WE (WB_SEL=PC4) and PC_WE (PC_SRC=ALUOut) in the same cycle.
REQ-020 With zero wait states, latency SHALL be: R/I/LUI 4 cycles, load 5, store 4, branch 3, JAL 3.
REQ-021 INSTR_DONE SHALL pulse in the last state of each instruction.
REQ-022 All strobes except IR_WE/PC_WE in FETCH and PC_WE in BRANCH SHALL be Moore-decoded from STATE.
REQ-023 At most one of REG_WE, MEM_WE SHALL be high in any cycle.

Reset
REQ-024 RST=1 SHALL asynchronously force STATE=FETCH, all strobes/selects/TRAP/TRAP_CAUSE/INSTR_DONE=0, and wait counter=0.
REQ-025 Reset mid-instruction (including during MEM_WR) SHALL drop MEM_WE/REG_WE in the same cycle, without waiting for CLK.
REQ-026 After RST deasserts, the first fetch SHALL begin at the next rising CLK edge.

Configuration
REQ-027 With macro MULTICYCLE_TRAP_EN defined, an illegal opcode SHALL enter TRAP with TRAP_CAUSE=01.
REQ-028 With MULTICYCLE_TRAP_EN defined, a wait of 2^WAIT_W-1 cycles in FETCH, MEM_RD or MEM_WR SHALL enter TRAP with TRAP_CAUSE=10.
REQ-029 TRAP SHALL be sticky: TRAP=1 and all strobes 0, with exit only by RST.
REQ-030 Without MULTICYCLE_TRAP_EN, an illegal opcode SHALL go DECODE->FETCH with an INSTR_DONE pulse (NOP), no wait counter SHALL exist, and TRAP/TRAP_CAUSE SHALL be tied 0.

Structure
REQ-031 Package multicycle_pkg SHALL hold the state enum, opcode constants, and the ALU_OP, ALU_SRC_*, WB_SEL and PC_SRC encodings.
REQ-032 Output decoding SHALL be one sub-module, mc_out_dec (combinational: STATE, FUNCT3, ZERO, MEM_READY -> control outputs); next-state logic and the counter SHALL stay in multicycle_ctrl.

Verification
REQ-033 The bench SHALL check: RST pulse mid-MEM_WR -> MEM_WE falls before the next edge, STATE=FETCH, and the first IR_WE comes 1 cycle after release with MEM_READY=1.
REQ-034 The bench SHALL check: add (0110011) with MEM_READY tied 1 -> FETCH, DECODE, EXEC_R, WB_ALU; REG_WE only in cycle 4; INSTR_DONE in cycle 4.
REQ-035 The bench SHALL check: lw with MEM_READY low 3 cycles in MEM_RD -> MEM_RE held 4 cycles, REG_WE 1 cycle in WB_MEM, 8 cycles total.
REQ-036 The bench SHALL check: beq with ZERO=1, then bne with ZERO=1 -> PC_WE=1 in BRANCH for the first and 0 for the second, 3 cycles each.
REQ-037 The bench SHALL check, with MULTICYCLE_TRAP_EN: opcode 1111111 -> TRAP=1, TRAP_CAUSE=01, held for 20 cycles; then MEM_READY stuck 0 in FETCH with WAIT_W=4 -> TRAP_CAUSE=10 after 15 cycles.
REQ-038 The bench SHALL check, without MULTICYCLE_TRAP_EN: opcode 1111111 -> FETCH after DECODE with INSTR_DONE=1 and TRAP=0.
